rv32i_mem_arbiter: RTL and testbench

//  Shares the single-port SoC memory between the core's instruction-fetch bus (ibus) and its

---
 rtl/rv32i_mem_arbiter_pkg.sv | 18 +
 rtl/rv32i_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types and constants for the rv32i instruction/data memory arbiter.
package rv32i_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StAck   = 2'd3
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates the single-port SoC memory between the core's ibus and dbus, one access at a time,
// with registered data/ack outputs and out-of-range error reporting.
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 8192,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ibus_stb,
  input  logic [31:0] i_ibus_addr,
  output logic        o_ibus_ack,
  output logic        o_ibus_err,
  output logic [31:0] o_ibus_rdata,
  input  logic        i_dbus_stb,
  input  logic        i_dbus_wr_en,
  input  logic [31:0] i_dbus_addr,
  input  logic [31:0] i_dbus_wdata,
  input  logic [3:0]  i_dbus_wr_mask,
  output logic        o_dbus_ack,
  output logic        o_dbus_err,
  output logic [31:0] o_dbus_rdata,
  output logic        o_mem_en,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wr_mask,
  input  logic [31:0] i_mem_rdata
);

  arb_state_e  r_state, w_state;
  logic        r_owner, w_owner;
  logic [2:0]  r_lat_cnt, w_lat_cnt;
  logic [3:0]  r_starve_cnt, w_starve_cnt;
  logic        r_ibus_ack, w_ibus_ack, r_ibus_err, w_ibus_err;
  logic        r_dbus_ack, w_dbus_ack, r_dbus_err, w_dbus_err;
  logic [31:0] r_ibus_rdata, w_ibus_rdata, r_dbus_rdata, w_dbus_rdata;
  logic        r_mem_en, w_mem_en, r_mem_wr_en, w_mem_wr_en;
  logic [31:0] r_mem_addr, w_mem_addr, r_mem_wdata, w_mem_wdata;
  logic [3:0]  r_mem_wr_mask, w_mem_wr_mask;

  logic        w_grant_i, w_grant_d;
  logic [31:0] w_req_addr;
  logic [31:0] w_cap_data;

  // ibus wins only when it is alone or dbus has used up its starvation allowance.
  assign w_grant_i  = i_ibus_stb && (!i_dbus_stb || (r_starve_cnt == 4'(STARVE_LIMIT)));
  assign w_grant_d  = i_dbus_stb && !w_grant_i;
  assign w_req_addr = w_grant_i ? i_ibus_addr : i_dbus_addr;
  assign w_cap_data = r_mem_wr_en ? 32'h0 : i_mem_rdata;

  always_comb begin
    w_state       = r_state;
    w_owner       = r_owner;
    w_lat_cnt     = r_lat_cnt;
    w_starve_cnt  = r_starve_cnt;
    w_ibus_ack    = 1'b0;
    w_ibus_err    = 1'b0;
    w_dbus_ack    = 1'b0;
    w_dbus_err    = 1'b0;
    w_ibus_rdata  = r_ibus_rdata;
    w_dbus_rdata  = r_dbus_rdata;
    w_mem_en      = 1'b0;
    w_mem_wr_en   = r_mem_wr_en;
    w_mem_addr    = r_mem_addr;
    w_mem_wdata   = r_mem_wdata;
    w_mem_wr_mask = r_mem_wr_mask;

    unique case (r_state)
      StIdle: begin
        if (w_grant_d && i_ibus_stb) begin
          w_starve_cnt = sat_inc4(r_starve_cnt);
        end else if (w_grant_i || !i_ibus_stb) begin
          w_starve_cnt = 4'd0;
        end
        if (w_grant_i || w_grant_d) begin
          w_owner       = w_grant_d ? OWN_D : OWN_I;
          w_mem_addr    = w_req_addr;
          w_mem_wr_en   = w_grant_d && i_dbus_wr_en;
          w_mem_wdata   = w_grant_d ? i_dbus_wdata : 32'h0;
          w_mem_wr_mask = w_grant_d ? i_dbus_wr_mask : 4'h0;
          if (w_req_addr >= 32'(MEMORY_DEPTH)) begin
            w_state = StAck;
            if (w_grant_d) begin
              w_dbus_ack   = 1'b1;
              w_dbus_err   = 1'b1;
              w_dbus_rdata = 32'h0;
            end else begin
              w_ibus_ack   = 1'b1;
              w_ibus_err   = 1'b1;
              w_ibus_rdata = 32'h0;
            end
          end else begin
            w_mem_en = 1'b1;
            w_state  = StIssue;
          end
        end
      end
      StIssue: begin
        w_lat_cnt = 3'(READ_LATENCY);
        w_state   = StWait;
      end
      StWait: begin
        w_lat_cnt = r_lat_cnt - 3'd1;
        if (r_lat_cnt == 3'd1) begin
          w_state = StAck;
          if (r_owner == OWN_D) begin
            w_dbus_ack   = 1'b1;
            w_dbus_rdata = w_cap_data;
          end else begin
            w_ibus_ack   = 1'b1;
            w_ibus_rdata = w_cap_data;
          end
        end
      end
      StAck: begin
        w_state = StIdle;
      end
      default: begin
        w_state = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_owner       <= OWN_I;
      r_lat_cnt     <= 3'd0;
      r_starve_cnt  <= 4'd0;
      r_ibus_ack    <= 1'b0;
      r_ibus_err    <= 1'b0;
      r_dbus_ack    <= 1'b0;
      r_dbus_err    <= 1'b0;
      r_ibus_rdata  <= 32'h0;
      r_dbus_rdata  <= 32'h0;
      r_mem_en      <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_wdata   <= 32'h0;
      r_mem_wr_mask <= 4'h0;
    end else begin
      r_state       <= w_state;
      r_owner       <= w_owner;
      r_lat_cnt     <= w_lat_cnt;
      r_starve_cnt  <= w_starve_cnt;
      r_ibus_ack    <= w_ibus_ack;
      r_ibus_err    <= w_ibus_err;
      r_dbus_ack    <= w_dbus_ack;
      r_dbus_err    <= w_dbus_err;
      r_ibus_rdata  <= w_ibus_rdata;
      r_dbus_rdata  <= w_dbus_rdata;
      r_mem_en      <= w_mem_en;
      r_mem_wr_en   <= w_mem_wr_en;
      r_mem_addr    <= w_mem_addr;
      r_mem_wdata   <= w_mem_wdata;
      r_mem_wr_mask <= w_mem_wr_mask;
    end
  end

  assign o_ibus_ack    = r_ibus_ack;
  assign o_ibus_err    = r_ibus_err;
  assign o_ibus_rdata  = r_ibus_rdata;
  assign o_dbus_ack    = r_dbus_ack;
  assign o_dbus_err    = r_dbus_err;
  assign o_dbus_rdata  = r_dbus_rdata;
  assign o_mem_en      = r_mem_en;
  assign o_mem_wr_en   = r_mem_wr_en;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_mem_wr_mask = r_mem_wr_mask;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: vector table plus scoreboard of expected acks.
module tb_rv32i_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // DUT with READ_LATENCY=1
  logic        ibus_stb = 1'b0, ibus_ack, ibus_err;
  logic [31:0] ibus_addr = 32'h0, ibus_rdata;
  logic        dbus_stb = 1'b0, dbus_wr_en = 1'b0, dbus_ack, dbus_err;
  logic [31:0] dbus_addr = 32'h0, dbus_wdata = 32'h0, dbus_rdata;
  logic [3:0]  dbus_mask = 4'h0;
  logic        mem_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;

  rv32i_mem_arbiter #(.MEMORY_DEPTH(8192), .READ_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_stb(ibus_stb), .i_ibus_addr(ibus_addr),
    .o_ibus_ack(ibus_ack), .o_ibus_err(ibus_err), .o_ibus_rdata(ibus_rdata),
    .i_dbus_stb(dbus_stb), .i_dbus_wr_en(dbus_wr_en), .i_dbus_addr(dbus_addr),
    .i_dbus_wdata(dbus_wdata), .i_dbus_wr_mask(dbus_mask),
    .o_dbus_ack(dbus_ack), .o_dbus_err(dbus_err), .o_dbus_rdata(dbus_rdata),
    .o_mem_en(mem_en), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wr_mask(mem_mask), .i_mem_rdata(mem_rdata)
  );

  // DUT with READ_LATENCY=3, fetch side only
  logic        i3_stb = 1'b0, i3_ack, i3_err;
  logic [31:0] i3_addr = 32'h0, i3_rdata;
  logic        d3_stb = 1'b0, d3_wr_en = 1'b0, d3_ack, d3_err;
  logic [31:0] d3_addr = 32'h0, d3_wdata = 32'h0, d3_rdata;
  logic [3:0]  d3_mask = 4'h0;
  logic        m3_en, m3_wr_en;
  logic [31:0] m3_addr, m3_wdata, m3_rdata;
  logic [3:0]  m3_mask;

  rv32i_mem_arbiter #(.MEMORY_DEPTH(8192), .READ_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_stb(i3_stb), .i_ibus_addr(i3_addr),
    .o_ibus_ack(i3_ack), .o_ibus_err(i3_err), .o_ibus_rdata(i3_rdata),
    .i_dbus_stb(d3_stb), .i_dbus_wr_en(d3_wr_en), .i_dbus_addr(d3_addr),
    .i_dbus_wdata(d3_wdata), .i_dbus_wr_mask(d3_mask),
    .o_dbus_ack(d3_ack), .o_dbus_err(d3_err), .o_dbus_rdata(d3_rdata),
    .o_mem_en(m3_en), .o_mem_wr_en(m3_wr_en), .o_mem_addr(m3_addr),
    .o_mem_wdata(m3_wdata), .o_mem_wr_mask(m3_mask), .i_mem_rdata(m3_rdata)
  );

  // Memory model; read data is garbage outside the single valid cycle.
  logic [31:0] mem [2048];
  logic        rd_vld1 = 1'b0;
  logic [31:0] rd_dat1 = 32'h0;
  logic [2:0]  vld3 = 3'b0;
  logic [31:0] dat3 [3];

  always @(posedge clk) begin
    if (mem_en && mem_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) mem[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    rd_vld1 <= mem_en && !mem_wr_en;
    rd_dat1 <= mem[mem_addr[12:2]];
    vld3    <= {vld3[1:0], m3_en && !m3_wr_en};
    dat3[0] <= mem[m3_addr[12:2]];
    dat3[1] <= dat3[0];
    dat3[2] <= dat3[1];
  end

  assign mem_rdata = rd_vld1 ? rd_dat1 : (32'hBAD0_0000 | cyc);
  assign m3_rdata  = vld3[2] ? dat3[2] : (32'hBAD3_0000 | cyc);

  // Scoreboard of expected acks from the latency-1 DUT
  typedef struct {
    logic        port_d;
    logic        err;
    logic [31:0] rdata;
    int unsigned at_cyc;
  } exp_t;
  exp_t sb[$];

  int unsigned mem_cnt = 0, mem_cyc = 0;
  logic        mem_wr_s;
  logic [31:0] mem_addr_s, mem_wdata_s;
  logic [3:0]  mem_mask_s;

  always @(negedge clk) begin
    exp_t e;
    if (ibus_ack || dbus_ack) begin
      check("ack_onehot", 32'($countones({ibus_ack, dbus_ack})), 32'd1);
      check("ack_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ack_port", 32'(dbus_ack), 32'(e.port_d));
        check("ack_err", 32'(dbus_ack ? dbus_err : ibus_err), 32'(e.err));
        check("ack_rdata", dbus_ack ? dbus_rdata : ibus_rdata, e.rdata);
        check("ack_cycle", cyc, e.at_cyc);
      end
    end
    if (mem_en) begin
      mem_cnt++;
      mem_cyc     = cyc;
      mem_wr_s    = mem_wr_en;
      mem_addr_s  = mem_addr;
      mem_wdata_s = mem_wdata;
      mem_mask_s  = mem_mask;
    end
  end

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [9];

  task automatic run_vec(input vec_t v);
    int unsigned c0, mc0;
    bit done;
    @(posedge clk); #1;
    c0  = cyc;
    mc0 = mem_cnt;
    if (v.is_d) begin
      dbus_stb = 1'b1; dbus_wr_en = v.wr; dbus_addr = v.addr;
      dbus_wdata = v.wdata; dbus_mask = v.mask;
    end else begin
      ibus_stb = 1'b1; ibus_addr = v.addr;
    end
    sb.push_back('{v.is_d, v.exp_err, v.exp_rdata, c0 + (v.exp_err ? 1 : 3)});
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (v.is_d ? dbus_ack : ibus_ack) done = 1'b1;
    end
    check("ack_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    ibus_stb = 1'b0; dbus_stb = 1'b0;
    check("mem_access_count", mem_cnt - mc0, v.exp_err ? 32'd0 : 32'd1);
    if (!v.exp_err) begin
      check("mem_en_cycle", mem_cyc, c0 + 1);
      check("mem_addr", mem_addr_s, v.addr);
      check("mem_wr_en", 32'(mem_wr_s), 32'(v.wr));
      if (v.wr) begin
        check("mem_wdata", mem_wdata_s, v.wdata);
        check("mem_mask", 32'(mem_mask_s), 32'(v.mask));
      end
    end
  endtask

  initial begin
    int unsigned c0;
    bit done;
    for (int i = 0; i < 2048; i++) mem[i] = {16'hA5A5, 16'(i)};
    mem[4]     = 32'hDEADBEEF;
    mem[8]     = 32'h11112222;
    mem[11'h420] = 32'hAAAA5555;
    mem[11'h7FF] = 32'h0BADC0DE;

    //          is_d  wr    addr          wdata         mask   err   rdata
    tbl[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_1080, 32'h12345678, 4'h3, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_1080, 32'h0,        4'h0, 1'b0, 32'hAAAA5678};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,        4'h0, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_2004, 32'h0,        4'h0, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 32'h0000_1FFC, 32'h0,        4'h0, 1'b0, 32'h0BADC0DE};
    tbl[6] = '{1'b1, 1'b1, 32'h0000_0000, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D};
    tbl[8] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0, 1'b1, 32'h0};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 32'({ibus_ack, ibus_err, dbus_ack, dbus_err, mem_en, mem_wr_en}), 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Both strobes held: D,D,D,D,I repeating, one grant every 4 cycles.
    @(posedge clk); #1;
    c0 = cyc;
    ibus_stb = 1'b1; ibus_addr = 32'h10;
    dbus_stb = 1'b1; dbus_wr_en = 1'b0; dbus_addr = 32'h20;
    for (int k = 0; k < 7; k++) begin
      sb.push_back('{(k % 5) != 4, 1'b0, ((k % 5) != 4) ? 32'h11112222 : 32'hDEADBEEF,
                     c0 + 3 + 4 * k});
    end
    repeat (28) @(posedge clk);
    #1;
    ibus_stb = 1'b0; dbus_stb = 1'b0;
    repeat (8) @(negedge clk);
    check("starve_sb_drained", sb.size(), 32'd0);

    // Asynchronous reset while the fetch is waiting on memory.
    @(posedge clk); #1;
    ibus_stb = 1'b1; ibus_addr = 32'h10;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_flags", 32'({ibus_ack, ibus_err, dbus_ack, dbus_err, mem_en, mem_wr_en}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_mask", 32'(mem_mask), 32'd0);
    check("rst_ibus_rdata", ibus_rdata, 32'h0);
    check("rst_dbus_rdata", dbus_rdata, 32'h0);
    ibus_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_no_late_ack", sb.size(), 32'd0);
    run_vec(tbl[0]);

    // READ_LATENCY=3 fetch
    @(posedge clk); #1;
    c0 = cyc;
    i3_stb = 1'b1; i3_addr = 32'h10;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (m3_en) check("lat3_mem_en_cycle", cyc, c0 + 1);
      if (i3_ack) begin
        done = 1'b1;
        check("lat3_ack_cycle", cyc, c0 + 5);
        check("lat3_rdata", i3_rdata, 32'hDEADBEEF);
        check("lat3_err", 32'(i3_err), 32'd0);
      end
    end
    check("lat3_ack_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    i3_stb = 1'b0;
    repeat (4) @(negedge clk);
    check("lat3_no_dbus_ack", 32'(d3_ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
